// File: rtl/clock_display_receiver.sv
// clock_display_receiver: deserialises the serial display link into six BCD time digits.
module clock_display_receiver #(
  parameter int DIGITS      = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sr_clk_in,
  input  logic       sr_data_in,
  input  logic       sr_latch_in,
  output logic [3:0] hours_msd,
  output logic [3:0] hours_lsd,
  output logic [3:0] minutes_msd,
  output logic [3:0] minutes_lsd,
  output logic [3:0] seconds_msd,
  output logic [3:0] seconds_lsd,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       digit_err,
  output logic       busy
);
  localparam int FB = 4 * DIGITS;
  localparam int CW = $clog2(FB + 2);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] clk_s, dat_s, lat_s;
  logic clk_p, lat_p, clk_rise, lat_rise, data_sync;
  logic [0:0] state;
  logic [CW-1:0] bit_cnt, cnt_nx;
  logic [TW-1:0] idle_cnt;
  logic [FB-1:0] shreg, sh_nx, digits;
  logic bad_digit, timeout, len_ok;

  // Data is delayed through the same pipeline as the shift clock so the two stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s     <= '0;
      dat_s     <= '0;
      lat_s     <= '0;
      clk_p     <= 1'b0;
      lat_p     <= 1'b0;
      clk_rise  <= 1'b0;
      lat_rise  <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      clk_s     <= {clk_s[SYNC_STAGES-2:0], sr_clk_in};
      dat_s     <= {dat_s[SYNC_STAGES-2:0], sr_data_in};
      lat_s     <= {lat_s[SYNC_STAGES-2:0], sr_latch_in};
      clk_p     <= clk_s[SYNC_STAGES-1];
      lat_p     <= lat_s[SYNC_STAGES-1];
      clk_rise  <= clk_s[SYNC_STAGES-1] & ~clk_p;
      lat_rise  <= lat_s[SYNC_STAGES-1] & ~lat_p;
      data_sync <= dat_s[SYNC_STAGES-1];
    end
  end

  // A coincident shift is folded in before the latch is evaluated.
  always_comb begin
    cnt_nx    = clk_rise ? (bit_cnt == CW'(FB + 1) ? bit_cnt : bit_cnt + 1'b1) : bit_cnt;
    sh_nx     = clk_rise ? {shreg[FB-2:0], data_sync} : shreg;
    len_ok    = cnt_nx == CW'(FB);
    timeout   = state == SHIFT && !clk_rise && idle_cnt == TW'(TIMEOUT - 1);
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad_digit = bad_digit | (sh_nx[4*i +: 4] > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      shreg       <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      digit_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      digit_err   <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        shreg    <= sh_nx;
        idle_cnt <= (clk_rise || state == IDLE) ? '0 : idle_cnt + 1'b1;
        if (lat_rise) begin
          state     <= IDLE;
          bit_cnt   <= '0;
          frame_err <= !len_ok;
          digit_err <= len_ok && bad_digit;
          if (len_ok && !bad_digit) begin
            digits      <= sh_nx;
            frame_valid <= 1'b1;
          end
        end else if (timeout) begin
          state     <= IDLE;
          bit_cnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          bit_cnt <= cnt_nx;
          if (clk_rise) state <= SHIFT;
        end
      end
    end
  end

  assign busy        = state == SHIFT;
  assign hours_msd   = digits[23:20];
  assign hours_lsd   = digits[19:16];
  assign minutes_msd = digits[15:12];
  assign minutes_lsd = digits[11:8];
  assign seconds_msd = digits[7:4];
  assign seconds_lsd = digits[3:0];
endmodule

// File: tb/tb_clock_display_receiver.sv
// tb_clock_display_receiver: table-driven and randomized frames against a frame-level reference model.
module tb_clock_display_receiver;
  localparam int SYNC = 2;
  localparam int TO   = 64;
  localparam int H    = 4;

  logic clk = 0, rst_n = 0, en = 1, sck = 0, sdat = 0, slat = 0;
  logic [3:0] hm, hl, mm, ml, sm, sl;
  logic fv, fe, de, busy;
  int tests = 0, fails = 0;
  int nv = 0, nfe = 0, nde = 0;
  logic [23:0] md = 0;

  clock_display_receiver #(.DIGITS(6), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sr_clk_in(sck), .sr_data_in(sdat), .sr_latch_in(slat),
    .hours_msd(hm), .hours_lsd(hl), .minutes_msd(mm), .minutes_lsd(ml),
    .seconds_msd(sm), .seconds_lsd(sl), .frame_valid(fv), .frame_err(fe), .digit_err(de), .busy(busy));

  always #5 clk = ~clk;

  wire [23:0] disp = {hm, hl, mm, ml, sm, sl};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    nv  += int'(fv);
    nfe += int'(fe);
    nde += int'(de);
    if (int'(fv) + int'(fe) + int'(de) > 1) chk("pulse_exclusive", {fv, fe, de}, 0);
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdat = b; hold(H);
    sck = 1;  hold(H);
    sck = 0;
  endtask

  task automatic send_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic latch();
    hold(H);
    slat = 1; hold(H);
    slat = 0; hold(H);
  endtask

  // Reference: judge a whole frame from its bit count and nibble values.
  task automatic model(input int n, input logic [31:0] v, output int ev, output int ee, output int ed);
    int bad = 0;
    for (int i = 0; i < 6; i++) if (((v >> (4 * i)) & 32'hF) > 9) bad = 1;
    ev = 0; ee = 0; ed = 0;
    if (n != 24) ee = 1;
    else if (bad != 0) ed = 1;
    else begin ev = 1; md = v[23:0]; end
  endtask

  task automatic check_frame(input string name, input int v0, input int e0, input int d0,
                             input int ev, input int ee, input int ed, input logic [23:0] edig);
    hold(8);
    chk({name, "_valid"}, nv - v0, ev);
    chk({name, "_ferr"}, nfe - e0, ee);
    chk({name, "_derr"}, nde - d0, ed);
    chk({name, "_digits"}, disp, edig);
  endtask

  typedef struct {
    int nbits; logic [31:0] value;
    int ev; int ee; int ed; logic [23:0] edig;
  } vec_t;
  vec_t vt[6];

  initial begin
    int v0, e0, d0, ev, ee, ed, lat_fv, lat_busy, c;
    logic [31:0] v;
    vt[0] = '{24, 32'h123456, 1, 0, 0, 24'h123456};
    vt[1] = '{23, 32'h7FFFFF, 0, 1, 0, 24'h123456};
    vt[2] = '{24, 32'h000000, 1, 0, 0, 24'h000000};
    vt[3] = '{25, 32'h0123456, 0, 1, 0, 24'h000000};
    vt[4] = '{24, 32'h1A3456, 0, 0, 1, 24'h000000};
    vt[5] = '{24, 32'h235959, 1, 0, 0, 24'h235959};

    hold(3);
    chk("reset_digits", disp, 0);
    chk("reset_pulses", {fv, fe, de, busy}, 0);
    rst_n = 1; hold(3);

    // Latency: frame_valid exactly SYNC+2 cycles after latch pin rises, busy falls with it.
    send_bits(24, 32'h654321);
    hold(H);
    v0 = nv; lat_fv = -1; lat_busy = -1;
    slat = 1;
    for (int k = 1; k <= 12; k++) begin
      hold(1);
      if (fv && lat_fv < 0) lat_fv = k;
      if (!busy && lat_busy < 0) lat_busy = k;
    end
    slat = 0; hold(H);
    chk("latency_valid", lat_fv, SYNC + 2);
    chk("latency_busy", lat_busy, SYNC + 2);
    chk("latency_digits", disp, 24'h654321);
    chk("latency_one_pulse", nv - v0, 1);

    foreach (vt[i]) begin
      v0 = nv; e0 = nfe; d0 = nde;
      send_bits(vt[i].nbits, vt[i].value);
      latch();
      check_frame($sformatf("table%0d", i), v0, e0, d0, vt[i].ev, vt[i].ee, vt[i].ed, vt[i].edig);
    end
    md = 24'h235959;

    // Timeout after a partial frame, then a good frame.
    e0 = nfe;
    send_bits(10, 32'h3FF);
    c = -1;
    for (int k = 1; k <= 3 * TO && c < 0; k++) begin
      hold(1);
      if (fe) c = k;
    end
    tests++;
    if (c < TO / 2 || c > TO + SYNC + 2) begin
      fails++;
      $display("FAIL timeout_cycle: got %0d expected within %0d..%0d", c, TO / 2, TO + SYNC + 2);
    end
    hold(2);
    chk("timeout_busy", busy, 0);
    chk("timeout_one_err", nfe - e0, 1);
    v0 = nv; e0 = nfe; d0 = nde;
    send_bits(24, 32'h235959); latch();
    model(24, 32'h235959, ev, ee, ed);
    check_frame("post_timeout", v0, e0, d0, ev, ee, ed, md);

    // Enable dropped mid-frame discards the frame silently.
    v0 = nv; e0 = nfe; d0 = nde;
    send_bits(12, 32'hABC);
    en = 0; hold(10); en = 1; hold(4);
    send_bits(24, 32'h102030); latch();
    model(24, 32'h102030, ev, ee, ed);
    check_frame("en_drop", v0, e0, d0, ev, ee, ed, md);

    // 24th shift edge coincident with the latch edge.
    v0 = nv; e0 = nfe; d0 = nde;
    send_bits(23, 32'h214253 >> 1);
    sdat = 1; hold(H);
    sck = 1; slat = 1; hold(H);
    sck = 0; slat = 0; hold(H);
    model(24, 32'h214253, ev, ee, ed);
    check_frame("coincident", v0, e0, d0, ev, ee, ed, md);

    // Randomized frames, mostly full-length, digits sometimes out of BCD range.
    for (int r = 0; r < 20; r++) begin
      int n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(22, 26)) : 24;
      v = 0;
      for (int i = 0; i < 6; i++) v[4*i +: 4] = 4'($urandom_range(0, ($urandom_range(0, 4) == 0) ? 15 : 9));
      v = v | (32'($urandom_range(0, 3)) << 24);
      v0 = nv; e0 = nfe; d0 = nde;
      send_bits(n, v); latch();
      model(n, v & ((32'h1 << n) - 1), ev, ee, ed);
      check_frame($sformatf("rand%0d", r), v0, e0, d0, ev, ee, ed, md);
    end

    // Reset mid-frame clears everything at once.
    send_bits(12, 32'h5A5);
    rst_n = 0; #1;
    chk("midreset_digits", disp, 0);
    chk("midreset_flags", {fv, fe, de, busy}, 0);
    hold(2); rst_n = 1; hold(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
